// File: rtl/audio_capture_pkg.sv
// ============================================================================
// Module   : audio_capture_pkg
// Brief    : Shared types and constants for the audio capture MM writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package audio_capture_pkg;

    localparam int         SAMPLE_W = 16;
    localparam logic [3:0] BE_FULL  = 4'hF;
    localparam logic [3:0] BE_LOW   = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/audio_capture_mm_writer_packer.sv
// ============================================================================
// Module   : sample_packer_16to32
// Brief    : Pairs 16-bit samples into 32-bit words, low sample first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sample_packer_16to32
    import audio_capture_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  take_partial,
    input  logic [SAMPLE_W-1:0]   sample,
    output logic                  half,
    output logic [SAMPLE_W-1:0]   low,
    output logic                  word_done,
    output logic [2*SAMPLE_W-1:0] word
);

    logic                r_half;
    logic [SAMPLE_W-1:0] r_low;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_half <= 1'b0;
            r_low  <= '0;
        end else begin
            if (clear || take_partial) begin
                r_half <= 1'b0;
            end else if (accept) begin
                r_half <= ~r_half;
            end
            if (accept && !r_half) begin
                r_low <= sample;
            end
        end
    end

    // The completed word is presented combinationally so the write stage can
    // register it on the same edge that accepts the high sample.
    assign half      = r_half;
    assign low       = r_low;
    assign word_done = accept && r_half;
    assign word      = {sample, r_low};

endmodule

`default_nettype wire

// File: rtl/audio_capture_mm_writer.sv
// ============================================================================
// Module   : audio_capture_mm_writer
// Brief    : Avalon-MM write master packing audio samples into a RAM buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module audio_capture_mm_writer
    import audio_capture_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DEPTH_WORDS = 100000,
    parameter int BASE_WORD   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              oneshot,
    input  logic              snk_valid,
    input  logic [15:0]       snk_data,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic              m_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-1:0] words_written
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_WORD);
    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_oneshot;
    logic                r_pending;
    logic                r_wrapped;
    logic                r_clken;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [31:0]         r_data;
    logic [3:0]          r_be;

    logic                w_accept;
    logic                w_half;
    logic [SAMPLE_W-1:0] w_low;
    logic                w_word_done;
    logic [31:0]         w_word;
    logic                w_wr_done;
    logic                w_at_last;
    logic                w_full_stop;
    logic                w_oneshot_full;
    logic                w_start_ok;
    logic                w_flush_partial;

    assign w_accept        = snk_valid && snk_ready;
    assign w_wr_done       = r_pending && !m_waitrequest;
    assign w_at_last       = (r_wr_ptr == c_last);
    assign w_full_stop     = r_oneshot && w_wr_done && w_at_last;
    // Once the final one-shot word is in the write stage nothing more may be taken.
    assign w_oneshot_full  = r_oneshot && r_pending && w_at_last;
    assign w_start_ok      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_flush_partial = (r_state == ST_FLUSH) && !r_pending && w_half;

    sample_packer_16to32 u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (w_start_ok),
        .accept       (w_accept),
        .take_partial (w_flush_partial),
        .sample       (snk_data),
        .half         (w_half),
        .low          (w_low),
        .word_done    (w_word_done),
        .word         (w_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_full_stop)  w_state_next = ST_DONE;
                else if (stop)    w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_full_stop || (!r_pending && !w_half)) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        snk_ready = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                busy      = 1'b1;
                snk_ready = !(r_pending && w_half) && !w_oneshot_full;
            end
            ST_FLUSH: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clken   <= 1'b0;
            r_oneshot <= 1'b0;
            r_pending <= 1'b0;
            r_wrapped <= 1'b0;
            r_wr_ptr  <= '0;
            r_data    <= '0;
            r_be      <= '0;
        end else begin
            r_clken <= 1'b1;
            if (w_start_ok) begin
                r_oneshot <= oneshot;
                r_pending <= 1'b0;
                r_wrapped <= 1'b0;
                r_wr_ptr  <= '0;
            end else begin
                if (w_wr_done) begin
                    r_pending <= 1'b0;
                    // One-shot leaves the pointer at DEPTH_WORDS as the final count.
                    if (!r_oneshot && w_at_last) begin
                        r_wr_ptr  <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + c_one;
                    end
                end
                if (w_word_done) begin
                    r_pending <= 1'b1;
                    r_data    <= w_word;
                    r_be      <= BE_FULL;
                end else if (w_flush_partial) begin
                    r_pending <= 1'b1;
                    r_data    <= {16'h0000, w_low};
                    r_be      <= BE_LOW;
                end
            end
        end
    end

    assign m_write       = r_pending;
    assign m_chipselect  = r_pending;
    assign m_address     = r_pending ? (c_base + r_wr_ptr) : '0;
    assign m_writedata   = r_data;
    assign m_byteenable  = r_be;
    assign m_clken       = r_clken;
    assign wrapped       = r_wrapped;
    assign words_written = r_wr_ptr;

endmodule

`default_nettype wire
